uart_xmit_fifo: RTL and testbench

UART_XMIT_FIFO -- requirements
Module: uart_xmit_fifo

---
 rtl/uart_xmit_fifo.sv | 167 ++++++++++++++++
 tb/tb_uart_xmit_fifo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_xmit_fifo.sv
// UART transmitter with a small byte FIFO in front of it.
// Frames are 8N1 (optionally 8E1/8O1), LSB first, and back-to-back when the FIFO holds more data.
module uart_xmit_fifo #(
  parameter int CELL_CNT   = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       sys_clk,
  input  logic       sys_rst_l,
  input  logic       wr_enH,
  input  logic [7:0] wr_dataH,
  output logic       fifo_fullH,
  output logic       fifo_emptyH,
  output logic       overflowH,
  output logic       uart_xmitH,
  output logic       xmit_busyH,
  output logic       xmit_doneH
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(CELL_CNT);
  localparam logic [CW-1:0] CELL_LAST = CW'(CELL_CNT - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    r_state;
  logic [CW-1:0] r_cell;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic          r_done;
  logic          r_overflow;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_mem [FIFO_DEPTH];

  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_cell_last;
  logic       w_bit_adv;
  logic [2:0] w_state_nxt;
  logic [7:0] w_head;

  assign w_full      = (r_count == DEPTH_CNT);
  assign w_empty     = (r_count == '0);
  // Full is judged on the pre-edge occupancy, so a same-edge pop never frees room for a write.
  assign w_push      = wr_enH & ~w_full;
  assign w_cell_last = (r_cell == CELL_LAST);
  assign w_head      = r_mem[r_rd_ptr];

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_bit_adv   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_cell_last) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_cell_last) begin
          w_bit_adv = 1'b1;
          if (r_bit_idx == 3'd7) w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_cell_last) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_cell_last) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all state below is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      r_state   <= S_IDLE;
      r_cell    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == S_STOP) && w_cell_last;

      if ((w_state_nxt != r_state) || w_bit_adv) r_cell <= '0;
      else if (r_state != S_IDLE)                r_cell <= r_cell + 1'b1;

      if ((w_state_nxt == S_DATA) && (r_state != S_DATA)) r_bit_idx <= '0;
      else if (w_bit_adv)                                 r_bit_idx <= r_bit_idx + 1'b1;

      if (w_pop) begin
        r_shift  <= w_head;
        r_parity <= (^w_head) ^ (PARITY_ODD != 0);
      end else if (w_bit_adv) begin
        r_shift  <= {1'b0, r_shift[7:1]};
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (wr_enH && w_full) r_overflow <= 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count alone define what is valid.
  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_dataH;
  end

  always_comb begin
    uart_xmitH = 1'b1;
    case (r_state)
      S_IDLE:   uart_xmitH = 1'b1;
      S_START:  uart_xmitH = 1'b0;
      S_DATA:   uart_xmitH = r_shift[0];
      S_PARITY: uart_xmitH = r_parity;
      S_STOP:   uart_xmitH = 1'b1;
      default:  uart_xmitH = 1'b1;
    endcase
  end

  assign fifo_fullH  = w_full;
  assign fifo_emptyH = w_empty;
  assign overflowH   = r_overflow;
  assign xmit_busyH  = (r_state != S_IDLE);
  assign xmit_doneH  = r_done;

endmodule

// File: tb/tb_uart_xmit_fifo.sv
// Bench for uart_xmit_fifo: one 8N1 instance plus even- and odd-parity instances sharing the write port.
// Frame shapes come from a hand-computed vector table; FIFO corner cases use directed sequences.
module tb_uart_xmit_fifo;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [2:0] full;
  logic [2:0] empty;
  logic [2:0] ovf;
  logic [2:0] line;
  logic [2:0] busy;
  logic [2:0] done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_cnt = 0;
  int   done_cyc_q[$];
  logic done_line_q[$];

  uart_xmit_fifo #(.CELL_CNT(16), .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
    .sys_clk(clk), .sys_rst_l(rst_n), .wr_enH(wr_en), .wr_dataH(wr_data),
    .fifo_fullH(full[0]), .fifo_emptyH(empty[0]), .overflowH(ovf[0]),
    .uart_xmitH(line[0]), .xmit_busyH(busy[0]), .xmit_doneH(done[0]));

  uart_xmit_fifo #(.CELL_CNT(16), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_even (
    .sys_clk(clk), .sys_rst_l(rst_n), .wr_enH(wr_en), .wr_dataH(wr_data),
    .fifo_fullH(full[1]), .fifo_emptyH(empty[1]), .overflowH(ovf[1]),
    .uart_xmitH(line[1]), .xmit_busyH(busy[1]), .xmit_doneH(done[1]));

  uart_xmit_fifo #(.CELL_CNT(16), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(1)) u_dut_odd (
    .sys_clk(clk), .sys_rst_l(rst_n), .wr_enH(wr_en), .wr_dataH(wr_data),
    .fifo_fullH(full[2]), .fifo_emptyH(empty[2]), .overflowH(ovf[2]),
    .uart_xmitH(line[2]), .xmit_busyH(busy[2]), .xmit_doneH(done[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every done pulse of the 8N1 instance with its cycle stamp and the line level in that cycle.
  always @(negedge clk) begin
    if (done[0] === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc_q.push_back(cyc);
      done_line_q.push_back(line[0]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  data;
    logic [10:0] cells;  // expected line level per bit cell, cell 0 in bit 0
    int          ncells;
    int          dut;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Writes one byte into an idle, empty transmitter and checks the whole frame cell by cell.
  task automatic run_frame(input vec_t v, input string nm);
    int bad;
    int d;
    d = v.dut;
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = v.data;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    check({nm, " line still idle after write"}, line[d], 1'b1);
    @(posedge clk);
    #1;
    check({nm, " line falls one edge after write"}, line[d], 1'b0);
    for (int k = 0; k < v.ncells; k++) begin
      bad = 0;
      for (int j = 0; j < 16; j++) begin
        @(negedge clk);
        if (line[d] !== v.cells[k]) bad++;
        if (done[d] !== 1'b0) bad++;
        if (busy[d] !== 1'b1) bad++;
      end
      check($sformatf("%s cell%0d bad samples", nm, k), bad, 0);
    end
    @(negedge clk);
    check({nm, " done pulse after last stop cycle"}, done[d], 1'b1);
    check({nm, " busy clear after frame"}, busy[d], 1'b0);
    check({nm, " line idle after frame"}, line[d], 1'b1);
    @(negedge clk);
    check({nm, " done is one cycle wide"}, done[d], 1'b0);
  endtask

  initial begin
    int base;
    int qbase;
    int lows;
    int c1;

    // Expected cells: {stop, [parity], d7..d0, start}.
    vecs[0] = '{data: 8'hA5, cells: 11'h34A, ncells: 10, dut: 0};
    vecs[1] = '{data: 8'h00, cells: 11'h200, ncells: 10, dut: 0};
    vecs[2] = '{data: 8'hFF, cells: 11'h3FE, ncells: 10, dut: 0};
    vecs[3] = '{data: 8'h3C, cells: 11'h278, ncells: 10, dut: 0};
    vecs[4] = '{data: 8'h07, cells: 11'h60E, ncells: 11, dut: 1};
    vecs[5] = '{data: 8'h07, cells: 11'h40E, ncells: 11, dut: 2};

    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;

    repeat (2) @(negedge clk);
    check("reset line", line[0], 1'b1);
    check("reset empty", empty[0], 1'b1);
    check("reset full", full[0], 1'b0);
    check("reset overflow", ovf[0], 1'b0);
    check("reset busy", busy[0], 1'b0);
    check("reset done", done[0], 1'b0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no frame without write: busy", busy[0], 1'b0);
    check("no frame without write: line", line[0], 1'b1);

    for (int i = 0; i < 4; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    do_reset();
    run_frame(vecs[4], "even parity 0x07");
    do_reset();
    run_frame(vecs[5], "odd parity 0x07");

    // Back-to-back frames: no idle gap, done pulses 160 cycles apart.
    do_reset();
    base  = done_cnt;
    qbase = done_cyc_q.size();
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h55;
    @(negedge clk); wr_data = 8'hAA;
    @(negedge clk); wr_en = 1'b0;
    for (int i = 0; i < 500 && done_cnt < base + 2; i++) @(negedge clk);
    check("b2b done pulses", done_cnt - base, 2);
    if (done_cyc_q.size() >= qbase + 2) begin
      check("b2b done spacing", done_cyc_q[qbase+1] - done_cyc_q[qbase], 160);
      check("b2b line low right after first stop", done_line_q[qbase], 1'b0);
      check("b2b line idle after second stop", done_line_q[qbase+1], 1'b1);
    end else begin
      check("b2b done log length", done_cyc_q.size() - qbase, 2);
    end

    // Overflow: six writes in a row, first pops immediately, sixth is dropped.
    do_reset();
    base = done_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
    end
    @(negedge clk);
    check("ovf: full after five writes", full[0], 1'b1);
    check("ovf: no overflow yet", ovf[0], 1'b0);
    wr_data = 8'hEE;
    @(negedge clk);
    wr_en = 1'b0;
    check("ovf: overflow after sixth write", ovf[0], 1'b1);
    check("ovf: still full", full[0], 1'b1);
    for (int i = 0; i < 1200 && done_cnt < base + 5; i++) @(negedge clk);
    repeat (300) @(negedge clk);
    check("ovf: exactly five frames", done_cnt - base, 5);
    check("ovf: fifo drained", empty[0], 1'b1);
    check("ovf: overflow sticky", ovf[0], 1'b1);

    // Reset during data bit 3 of 0x07 (a zero bit) with a second byte queued.
    do_reset();
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h07;
    @(negedge clk); wr_data = 8'h33;
    @(negedge clk); wr_en = 1'b0;
    repeat (72) @(negedge clk);
    check("mid-frame: data bit 3 low", line[0], 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid-frame reset: line high", line[0], 1'b1);
    check("mid-frame reset: empty", empty[0], 1'b1);
    check("mid-frame reset: busy low", busy[0], 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = done_cnt;
    lows = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (line[0] !== 1'b1 || busy[0] !== 1'b0) lows++;
    end
    check("post-reset: line stays idle", lows, 0);
    check("post-reset: no done pulses", done_cnt - base, 0);

    // Full FIFO and a write on the very edge the machine pops from STOP.
    do_reset();
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h21;
    @(negedge clk); wr_data = 8'h22;
    @(negedge clk); wr_data = 8'h23;
    c1 = cyc;
    @(negedge clk); wr_data = 8'h24;
    @(negedge clk); wr_data = 8'h25;
    @(negedge clk); wr_en = 1'b0;
    check("full+pop: full before pop", full[0], 1'b1);
    check("full+pop: no overflow yet", ovf[0], 1'b0);
    for (int i = 0; i < 300 && cyc < c1 + 159; i++) @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h99;
    @(negedge clk);
    wr_en = 1'b0;
    check("full+pop: write dropped sets overflow", ovf[0], 1'b1);
    check("full+pop: not full after pop", full[0], 1'b0);
    check("full+pop: next frame started", line[0], 1'b0);
    wr_en = 1'b1; wr_data = 8'h77;
    @(negedge clk);
    wr_en = 1'b0;
    check("full+pop: one write refills to full", full[0], 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
